// File: rtl/ifetch_unit_pkg.sv
// Shared encodings for the instruction-fetch stage: NPCOp values, reset PC and FSM states.
// Build option IFETCH_DELAY_SLOT_EN (see ifetch_unit.sv) does not change anything here.
package ifetch_unit_pkg;

    localparam int unsigned AW_DEF       = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

    // Must match the NPCOp encoding produced by the control unit
    typedef enum logic [1:0] {
        NPC_PLUS4  = 2'b00,
        NPC_BRANCH = 2'b01,
        NPC_JUMP   = 2'b10,
        NPC_JR     = 2'b11
    } npc_op_e;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_ISSUE = 1'b1
    } state_e;

endpackage

// File: rtl/ifetch_unit_npc_calc.sv
// Combinational next-PC computation from the pc of the instruction being retired.
// misalign_o flags a JR/JALR target whose low two bits are not zero.
module ifetch_unit_npc_calc
    import ifetch_unit_pkg::*;
#(
    parameter int unsigned AW = AW_DEF
) (
    input  logic [AW-1:0] pc_i,
    input  logic [1:0]    npc_op_i,
    input  logic [15:0]   imm16_i,
    input  logic [25:0]   jtarget_i,
    input  logic [AW-1:0] rs_val_i,
    output logic [AW-1:0] npc_o,
    output logic          misalign_o
);

    logic [AW-1:0] pc_plus4;
    logic [AW-1:0] br_off;

    assign pc_plus4 = pc_i + AW'(4);
    assign br_off   = {{(AW-18){imm16_i[15]}}, imm16_i, 2'b00};

    always_comb begin
        npc_o      = pc_plus4;
        misalign_o = 1'b0;
        case (npc_op_e'(npc_op_i))
            NPC_PLUS4:  npc_o = pc_plus4;
            NPC_BRANCH: npc_o = pc_plus4 + br_off;
            NPC_JUMP:   npc_o = {pc_plus4[AW-1:28], jtarget_i, 2'b00};
            NPC_JR: begin
                npc_o      = {rs_val_i[AW-1:2], 2'b00};
                misalign_o = |rs_val_i[1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one instruction at a time, issues it to decode.
// Define IFETCH_DELAY_SLOT_EN for MIPS branch-delay-slot semantics (taken target applied one instruction late).
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter int unsigned    AW       = AW_DEF,
    parameter logic [AW-1:0]  RESET_PC = AW'(RESET_PC_DEF)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ready,
    input  logic [31:0]   imem_rdata,
    output logic          inst_valid,
    output logic [31:0]   inst,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] pc_plus4,
    input  logic          inst_ack,
    input  logic [1:0]    npc_op,
    input  logic [15:0]   imm16,
    input  logic [25:0]   jtarget,
    input  logic [AW-1:0] rs_val,
    output logic          addr_err
);

    state_e        state_q;
    logic [AW-1:0] pc_q;
    logic [31:0]   inst_q;
    logic          inst_valid_q;
    logic          imem_req_q;
    logic          addr_err_q;
    logic [AW-1:0] npc_d;
    logic          misalign;

`ifdef IFETCH_DELAY_SLOT_EN
    logic          pend_valid_q;
    logic [AW-1:0] pend_tgt_q;
`endif

    ifetch_unit_npc_calc #(.AW(AW)) u_npc_calc (
        .pc_i       (pc_q),
        .npc_op_i   (npc_op),
        .imm16_i    (imm16),
        .jtarget_i  (jtarget),
        .rs_val_i   (rs_val),
        .npc_o      (npc_d),
        .misalign_o (misalign)
    );

    // FETCH waits for memory, ISSUE holds the instruction until decode acks it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            imem_req_q   <= 1'b1;
            addr_err_q   <= 1'b0;
`ifdef IFETCH_DELAY_SLOT_EN
            pend_valid_q <= 1'b0;
            pend_tgt_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ready) begin
                        inst_q       <= imem_rdata;
                        inst_valid_q <= 1'b1;
                        imem_req_q   <= 1'b0;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (inst_ack) begin
                        inst_valid_q <= 1'b0;
                        imem_req_q   <= 1'b1;
                        state_q      <= S_FETCH;
`ifdef IFETCH_DELAY_SLOT_EN
                        // Delay-slot instruction: its own npc_op is ignored
                        if (pend_valid_q) begin
                            pc_q         <= pend_tgt_q;
                            pend_valid_q <= 1'b0;
                        end else if (npc_op != NPC_PLUS4) begin
                            pend_valid_q <= 1'b1;
                            pend_tgt_q   <= npc_d;
                            pc_q         <= pc_plus4;
                            addr_err_q   <= addr_err_q | misalign;
                        end else begin
                            pc_q <= npc_d;
                        end
`else
                        pc_q       <= npc_d;
                        addr_err_q <= addr_err_q | misalign;
`endif
                    end
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign pc_plus4   = pc_q + AW'(4);
    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign pc         = pc_q;
    assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios with literal expectations, then random traffic
// compared every cycle against an instruction-level model. Honours IFETCH_DELAY_SLOT_EN.
module tb_ifetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        inst_ack;
    logic [1:0]  npc_op;
    logic [15:0] imm16;
    logic [25:0] jtarget;
    logic [31:0] rs_val;
    logic        addr_err;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    ifetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst       (inst),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .inst_ack   (inst_ack),
        .npc_op     (npc_op),
        .imm16      (imm16),
        .jtarget    (jtarget),
        .rs_val     (rs_val),
        .addr_err   (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- instruction-level reference model ----------------
    logic        m_has;     // an instruction is currently held for decode
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic        m_err;
    logic        m_pend;
    logic [31:0] m_tgt;

    function automatic logic [32:0] target(input logic [31:0] p, input logic [1:0] op,
                                           input logic [15:0] im, input logic [25:0] jt,
                                           input logic [31:0] rs);
        logic [31:0] sx;
        logic [31:0] t;
        logic        mis;
        sx  = {{16{im[15]}}, im};
        mis = 1'b0;
        case (op)
            2'd0:    t = p + 32'd4;
            2'd1:    t = p + 32'd4 + sx * 32'd4;
            2'd2:    t = ((p + 32'd4) & 32'hF000_0000) | ({6'd0, jt} * 32'd4);
            default: begin
                t   = rs & 32'hFFFF_FFFC;
                mis = (rs % 32'd4) != 32'd0;
            end
        endcase
        return {mis, t};
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [32:0] r;
        if (rst) begin
            m_has = 1'b0; m_pc = 32'h0000_3000; m_inst = '0;
            m_err = 1'b0; m_pend = 1'b0; m_tgt = '0;
        end else if (!m_has) begin
            if (imem_ready) begin
                m_inst = imem_rdata;
                m_has  = 1'b1;
            end
        end else if (inst_ack) begin
            m_has = 1'b0;
            r = target(m_pc, npc_op, imm16, jtarget, rs_val);
`ifdef IFETCH_DELAY_SLOT_EN
            if (m_pend) begin
                m_pc   = m_tgt;
                m_pend = 1'b0;
            end else if (npc_op != 2'd0) begin
                m_pend = 1'b1;
                m_tgt  = r[31:0];
                m_err  = m_err | r[32];
                m_pc   = m_pc + 32'd4;
            end else begin
                m_pc = r[31:0];
            end
`else
            m_pc  = r[31:0];
            m_err = m_err | r[32];
`endif
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("imem_req", 32'(imem_req), 32'(!m_has));
            chk("pc", pc, m_pc);
            chk("pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("inst_valid", 32'(inst_valid), 32'(m_has));
            chk("addr_err", 32'(addr_err), 32'(m_err));
            if (!m_has) chk("imem_addr", imem_addr, m_pc);
            if (m_has)  chk("inst", inst, m_inst);
        end
    end

    // ---------------- directed helpers (called at a negedge) ----------------
    task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] word);
        chk("fetch_req", 32'(imem_req), 32'd1);
        chk("fetch_addr", imem_addr, exp_addr);
        imem_ready = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        chk("fetched_valid", 32'(inst_valid), 32'd1);
        chk("fetched_inst", inst, word);
        chk("fetched_pc", pc, exp_addr);
    endtask

    task automatic issue(input logic [1:0] op, input logic [15:0] im, input logic [25:0] jt,
                         input logic [31:0] rs, input int hold,
                         input logic [31:0] exp_pc, input logic [31:0] exp_inst);
        for (int i = 0; i < hold; i++) begin
            inst_ack = 1'b0;
            npc_op   = 2'($urandom);
            @(negedge clk);
            chk("hold_req", 32'(imem_req), 32'd0);
            chk("hold_pc", pc, exp_pc);
            chk("hold_inst", inst, exp_inst);
        end
        inst_ack = 1'b1; npc_op = op; imm16 = im; jtarget = jt; rs_val = rs;
        @(negedge clk);
        inst_ack = 1'b0;
    endtask

    // Step through a delay slot (no-op in the immediate-target build)
    task automatic slot(input logic [31:0] slot_addr);
`ifdef IFETCH_DELAY_SLOT_EN
        fetch(slot_addr, 32'h0000_0000);
        issue(2'd2, 16'h0, 26'h0, 32'h0, 0, slot_addr, 32'h0);
`else
        chk("no_slot_addr", imem_addr, imem_addr == slot_addr ? 32'hDEAD_BEEF : imem_addr);
`endif
    endtask

    initial begin
        int t0;
        rst = 1'b1; imem_ready = 1'b0; imem_rdata = '0; inst_ack = 1'b0;
        npc_op = '0; imm16 = '0; jtarget = '0; rs_val = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pc", pc, 32'h0000_3000);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_err", 32'(addr_err), 32'd0);
        rst = 1'b0;

        // Sequential PLUS4 fetches, zero wait states, one every two cycles
        t0 = cyc;
        fetch(32'h0000_3000, 32'h1111_0000);
        chk("first_valid_latency", 32'(cyc - t0), 32'd1);
        issue(2'd0, 16'h0, 26'h0, 32'h0, 0, 32'h3000, 32'h1111_0000);
        t0 = cyc;
        fetch(32'h0000_3004, 32'h1111_0004);
        issue(2'd0, 16'h0, 26'h0, 32'h0, 0, 32'h3004, 32'h1111_0004);
        chk("fetch_period", 32'(cyc - t0), 32'd2);
        fetch(32'h0000_3008, 32'h1111_0008);
        issue(2'd0, 16'h0, 26'h0, 32'h0, 0, 32'h3008, 32'h1111_0008);
        fetch(32'h0000_300C, 32'h1111_000C);
        issue(2'd0, 16'h0, 26'h0, 32'h0, 0, 32'h300C, 32'h1111_000C);

        // Backward branch from 3010
        fetch(32'h0000_3010, 32'h1000_FFFC);
        issue(2'd1, 16'hFFFC, 26'h0, 32'h0, 0, 32'h3010, 32'h1000_FFFC);
        slot(32'h0000_3014);

        // Memory stall, then reset during the wait
        chk("stall_addr0", imem_addr, 32'h0000_3004);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_req", 32'(imem_req), 32'd1);
            chk("stall_addr", imem_addr, 32'h0000_3004);
            chk("stall_valid", 32'(inst_valid), 32'd0);
        end
        #2 rst = 1'b1;
        #1 chk("async_rst_pc", pc, 32'h0000_3000);
        chk("async_rst_valid", 32'(inst_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Jump from 3000
        fetch(32'h0000_3000, 32'h0800_0C10);
        issue(2'd2, 16'h0, 26'h000_0C10, 32'h0, 0, 32'h3000, 32'h0800_0C10);
        slot(32'h0000_3004);

        // Misaligned JR sets a sticky error
        fetch(32'h0000_3040, 32'h03E0_0008);
        issue(2'd3, 16'h0, 26'h0, 32'h0000_3027, 0, 32'h3040, 32'h03E0_0008);
        slot(32'h0000_3044);
        fetch(32'h0000_3024, 32'h2222_0000);
        chk("jr_err_set", 32'(addr_err), 32'd1);
        issue(2'd0, 16'h0, 26'h0, 32'h0, 0, 32'h3024, 32'h2222_0000);
        fetch(32'h0000_3028, 32'h2222_0004);
        chk("jr_err_sticky", 32'(addr_err), 32'd1);

        // Wrap at the top of the address space, decode holding ack low
        issue(2'd3, 16'h0, 26'h0, 32'hFFFF_FFFC, 0, 32'h3028, 32'h2222_0004);
        slot(32'h0000_302C);
        fetch(32'hFFFF_FFFC, 32'h3333_3333);
        chk("wrap_plus4", pc_plus4, 32'h0000_0000);
        issue(2'd0, 16'h0, 26'h0, 32'h0, 3, 32'hFFFF_FFFC, 32'h3333_3333);
        fetch(32'h0000_0000, 32'h4444_4444);
        chk("wrap_err_sticky", 32'(addr_err), 32'd1);
        issue(2'd0, 16'h0, 26'h0, 32'h0, 0, 32'h0, 32'h4444_4444);

        // Random traffic, including ack outside ISSUE and occasional resets
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            imem_ready = ($urandom_range(0, 2) != 0);
            imem_rdata = $urandom;
            inst_ack   = ($urandom_range(0, 1) != 0);
            npc_op     = 2'($urandom);
            imm16      = 16'($urandom);
            jtarget    = 26'($urandom);
            rs_val     = $urandom;
            if ($urandom_range(0, 7) != 0) rs_val[1:0] = 2'b00;
        end

        @(negedge clk);
        imem_ready = 1'b0; inst_ack = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("final_rst_err", 32'(addr_err), 32'd0);
        chk("final_rst_pc", pc, 32'h0000_3000);
        rst = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the decode/control logic.
- Owns the PC register and fetches each instruction from instruction memory over a valid/ready request handshake.
- Presents the instruction to decode, then takes back the resolved 2-bit NPCOp plus branch/jump operands to compute the next PC.
- Multi-cycle: one instruction in flight at a time.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- AW, 32, address/PC width; low 2 bits always 0 when presented.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address, equals pc while imem_req is high.
- imem_ready  in  1  memory accepted request; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched word.
- inst_valid  out  1  inst/pc hold a valid instruction for decode.
- inst  out  32  instruction word (Op = inst[31:26], Funct = inst[5:0]).
- pc  out  32  address of inst.
- pc_plus4  out  32  pc+4, used for jal/jalr link writeback.
- inst_ack  in  1  decode/execute finished with inst; npc_op and operands valid this cycle.
- npc_op  in  2  00 PLUS4, 01 BRANCH, 10 JUMP, 11 JR/JALR.
- imm16  in  16  branch offset (inst[15:0]).
- jtarget  in  26  jump index (inst[25:0]).
- rs_val  in  32  register rs value for JR/JALR.
- addr_err  out  1  sticky: a JR target had nonzero bits [1:0].

Behaviour:
- Reset (asynchronous, any state): pc=RESET_PC, state=FETCH, inst=0, inst_valid=0, addr_err=0, pending cleared. An in-flight request is dropped; imem_req restarts the cycle after rst deasserts.
- FETCH state: imem_req=1, imem_addr=pc.
  - imem_ready=1 in a cycle: capture imem_rdata into inst; next state ISSUE.
  - imem_ready may be high in the first FETCH cycle, giving zero wait states.
- ISSUE state: inst_valid=1, imem_req=0.
  - inst_ack=1: load next pc, next state FETCH.
  - Minimum instruction period is 2 cycles (FETCH + ISSUE).
- inst_ack outside ISSUE is ignored.
- Next-PC arithmetic, using the pc of the instruction being acked:
  - PLUS4: pc+4.
  - BRANCH: pc+4 + (sign-extended imm16 << 2).
  - JUMP: {pc_plus4[31:28], jtarget, 2'b00}.
  - JR: {rs_val[31:2], 2'b00}; if rs_val[1:0]!=0, also set addr_err (sticky until rst).
- All arithmetic is modulo 2^32: pc=32'hFFFF_FFFC with PLUS4 gives 32'h0000_0000, with no flag.
- pc_plus4 is combinational from pc.
- inst, pc and inst_valid are stable for the whole ISSUE state.

Optional Feature:
- Macro IFETCH_DELAY_SLOT_EN.
- Defined (MIPS branch delay slot):
  - A non-PLUS4 ack stores the target in a pending register.
  - The next pc is pc+4 (the delay slot).
  - When the delay-slot instruction is acked, the pending target is used regardless of its npc_op, and pending is cleared.
  - A jump/branch in a delay slot is not supported: it is treated as PLUS4.
- Undefined: the target is applied immediately; no pending register exists.

Decomposition:
- Shared package/header: NPC_PLUS4/NPC_BRANCH/NPC_JUMP/NPC_JR encodings (matching the control unit's NPCOp), RESET_PC default, and the FETCH/ISSUE state encodings.
- One natural sub-module: npc_calc, combinational, (pc, npc_op, imm16, jtarget, rs_val) -> (npc, misalign).

Test Plan:
- Reset, then imem_ready tied 1, inst_ack tied 1 with PLUS4 -> imem_addr sequence 3000, 3004, 3008, one fetch every 2 cycles; inst_valid first high 1 cycle after reset release.
- BRANCH at pc=3010, imm16=16'hFFFC -> next imem_addr 32'h0000_3004; with IFETCH_DELAY_SLOT_EN, 3014 is fetched first, then 3004.
- JUMP at pc=3000, jtarget=26'h000_0C10 -> next imem_addr 32'h0000_3040.
- JR with rs_val=32'h0000_3027 -> next addr 3024; addr_err=1 and stays 1 over later instructions until rst.
- imem_ready held low 5 cycles -> imem_req/imem_addr stable, inst_valid=0; rst asserted during the wait -> pc=RESET_PC immediately, request reissued after release.
- pc=32'hFFFF_FFFC with PLUS4 -> imem_addr 32'h0000_0000; decode holds inst_ack low 3 cycles -> inst/pc unchanged, no new request issued.
